// File: rtl/swap_pkg.sv
// Shared types for the swap_banco register bank: command encodings and
// controller states.
package swap_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_MOVE = 2'b01,
    OP_SWAP = 2'b10,
    OP_NOP  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MOV,
    ST_SW1,
    ST_SW2,
    ST_SW3,
    ST_FIM
  } state_t;

endpackage

// File: rtl/registrador_n.sv
// WIDTH-bit register with write enable and asynchronous active-low clear.
module registrador_n #(
  parameter int WIDTH = 6
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: state is updated with non-blocking assignments so every register
  // sampling the shared bus on the same edge sees the pre-edge value.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/swap_banco.sv
// Register bank with hidden temp on a single one-hot muxed bus; a small FSM
// runs LOAD/MOVE/SWAP as sequences of bus transfers behind start/done.
module swap_banco
  import swap_pkg::*;
#(
  parameter  int WIDTH = 6,
  parameter  int NREGS = 4,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    src,
  input  logic [AW-1:0]    dst,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] barramento,
  output logic             busy,
  output logic             done
);

  // Bus select bits: [0] data operand, [NREGS:1] registers, [NREGS+1] temp.
  localparam int NSEL = NREGS + 2;

  state_t               state, state_nx;
  logic [AW-1:0]        src_q, dst_q;
  logic [WIDTH-1:0]     data_q;
  logic [WIDTH-1:0]     regs [NREGS];
  logic [WIDTH-1:0]     temp_q;
  logic [NREGS-1:0]     reg_we;
  logic                 temp_we;
  logic [NSEL-1:0]      bus_sel;

  // One-hot decode of a register index; out-of-range indices decode to zero,
  // which both suppresses the write and leaves the bus undriven (reads 0).
  function automatic logic [NREGS-1:0] decode(input logic [AW-1:0] idx);
    decode = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (idx == AW'(i)) decode[i] = 1'b1;
    end
  endfunction

  // The opcode is consumed by the IDLE transition itself, so only the
  // operands need to be held for the rest of the command.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      data_q <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && start) begin
        src_q  <= src;
        dst_q  <= dst;
        data_q <= data_in;
      end
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    bus_sel  = '0;
    reg_we   = '0;
    temp_we  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          case (op_t'(op))
            OP_LOAD: state_nx = ST_LOAD;
            OP_MOVE: state_nx = ST_MOV;
            OP_SWAP: state_nx = ST_SW1;
            OP_NOP:  state_nx = ST_FIM;
          endcase
        end
      end
      ST_LOAD: begin
        bus_sel[0] = 1'b1;
        reg_we     = decode(dst_q);
        state_nx   = ST_FIM;
      end
      ST_MOV: begin
        bus_sel[NREGS:1] = decode(src_q);
        reg_we           = decode(dst_q);
        state_nx         = ST_FIM;
      end
      ST_SW1: begin
        bus_sel[NREGS:1] = decode(src_q);
        temp_we          = 1'b1;
        state_nx         = ST_SW2;
      end
      ST_SW2: begin
        bus_sel[NREGS:1] = decode(dst_q);
        reg_we           = decode(src_q);
        state_nx         = ST_SW3;
      end
      ST_SW3: begin
        bus_sel[NREGS+1] = 1'b1;
        reg_we           = decode(dst_q);
        state_nx         = ST_FIM;
      end
      ST_FIM: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // AND-OR mux: with at most one select bit set this is a plain bus.
  always_comb begin
    barramento = '0;
    if (bus_sel[0]) barramento = barramento | data_q;
    for (int i = 0; i < NREGS; i++) begin
      if (bus_sel[i+1]) barramento = barramento | regs[i];
    end
    if (bus_sel[NREGS+1]) barramento = barramento | temp_q;
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    registrador_n #(.WIDTH(WIDTH)) u_reg (
      .ck (ck),
      .rst(rst),
      .en (reg_we[g]),
      .d  (barramento),
      .q  (regs[g])
    );
  end

  registrador_n #(.WIDTH(WIDTH)) u_temp (
    .ck (ck),
    .rst(rst),
    .en (temp_we),
    .d  (barramento),
    .q  (temp_q)
  );

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_addr == AW'(i)) rd_data = regs[i];
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FIM);

endmodule

// File: tb/tb_swap_banco.sv
// Self-checking bench for swap_banco: default 6x4 instance plus an 8x5
// instance for the non-power-of-2 index behaviour.
module tb_swap_banco;

  logic       ck;
  logic       rst;

  logic       start;
  logic [1:0] op, src, dst, rd_addr;
  logic [5:0] data_in, rd_data, barramento;
  logic       busy, done;

  logic       start2;
  logic [1:0] op2;
  logic [2:0] src2, dst2, rd_addr2;
  logic [7:0] data2, rd_data2, bus2;
  logic       busy2, done2;

  swap_banco dut (
    .ck(ck), .rst(rst), .start(start), .op(op), .src(src), .dst(dst),
    .data_in(data_in), .rd_addr(rd_addr), .rd_data(rd_data),
    .barramento(barramento), .busy(busy), .done(done)
  );

  swap_banco #(.WIDTH(8), .NREGS(5)) dut2 (
    .ck(ck), .rst(rst), .start(start2), .op(op2), .src(src2), .dst(dst2),
    .data_in(data2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .barramento(bus2), .busy(busy2), .done(done2)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  always @(negedge ck) if (done) done_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic sync();
    @(posedge ck);
    #1;
  endtask

  // Reference register file and scoreboard of register values to verify.
  logic [5:0] m [4];
  typedef struct {
    logic [1:0] addr;
    logic [5:0] val;
  } sb_t;
  sb_t sb_q[$];

  task automatic run_cmd(input logic [1:0] o, input logic [1:0] s,
                         input logic [1:0] d, input logic [5:0] dat);
    logic [5:0] exp_bus[$];
    logic [5:0] a, b;
    sb_t e;
    a = m[s];
    b = m[d];
    case (o)
      2'b00: begin exp_bus.push_back(dat); m[d] = dat; end
      2'b01: begin exp_bus.push_back(a); m[d] = a; end
      2'b10: begin
        exp_bus.push_back(a); exp_bus.push_back(b); exp_bus.push_back(a);
        m[s] = b; m[d] = a;
      end
      default: ;
    endcase
    e.addr = d; e.val = m[d]; sb_q.push_back(e);
    e.addr = s; e.val = m[s]; sb_q.push_back(e);

    sync();
    op = o; src = s; dst = d; data_in = dat; start = 1'b1;
    @(posedge ck); #1;
    start = 1'b0;
    // Disturb the inputs: the captured command must be unaffected.
    data_in = ~dat; src = ~s; dst = ~d; op = ~o;
    foreach (exp_bus[i]) begin
      check("bus_transfer", barramento, exp_bus[i]);
      check("done_early", done, 1'b0);
      check("busy_active", busy, 1'b1);
      sync();
    end
    check("done_pulse", done, 1'b1);
    check("bus_idle_fim", barramento, 6'h00);
    sync();
    check("done_clear", done, 1'b0);
    check("busy_clear", busy, 1'b0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      rd_addr = e.addr;
      #1;
      check($sformatf("rd_r%0d", e.addr), rd_data, e.val);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [1:0] src;
    logic [1:0] dst;
    logic [5:0] data;
    logic [5:0] exp_dst;
  } vec_t;

  task automatic rd2_check(input string name, input logic [2:0] a, input logic [7:0] exp);
    rd_addr2 = a;
    #1;
    check(name, rd_data2, exp);
  endtask

  task automatic run2(input logic [1:0] o, input logic [2:0] s,
                      input logic [2:0] d, input logic [7:0] dat);
    int n;
    sync();
    op2 = o; src2 = s; dst2 = d; data2 = dat; start2 = 1'b1;
    @(posedge ck); #1;
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 10) begin
      sync();
      n++;
    end
    check("dut2_done", done2, 1'b1);
    sync();
  endtask

  initial begin
    vec_t vecs[8];
    int   cnt0;
    sb_t  e;

    vecs[0] = '{2'b00, 2'd0, 2'd2, 6'h3F, 6'h3F};
    vecs[1] = '{2'b01, 2'd1, 2'd3, 6'h00, 6'h15};
    vecs[2] = '{2'b10, 2'd2, 2'd2, 6'h00, 6'h3F};
    vecs[3] = '{2'b11, 2'd0, 2'd0, 6'h11, 6'h2A};
    vecs[4] = '{2'b10, 2'd3, 2'd0, 6'h00, 6'h15};
    vecs[5] = '{2'b00, 2'd0, 2'd1, 6'h00, 6'h00};
    vecs[6] = '{2'b01, 2'd0, 2'd2, 6'h00, 6'h15};
    vecs[7] = '{2'b10, 2'd2, 2'd1, 6'h00, 6'h15};

    rst = 1'b0; start = 1'b0; op = '0; src = '0; dst = '0; data_in = '0; rd_addr = '0;
    start2 = 1'b0; op2 = '0; src2 = '0; dst2 = '0; data2 = '0; rd_addr2 = '0;
    for (int i = 0; i < 4; i++) m[i] = '0;

    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bus", barramento, 6'h00);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      check($sformatf("rst_r%0d", i), rd_data, 6'h00);
    end
    #5 rst = 1'b1;

    run_cmd(2'b00, 2'd0, 2'd0, 6'h15);
    run_cmd(2'b00, 2'd0, 2'd1, 6'h2A);
    run_cmd(2'b10, 2'd0, 2'd1, 6'h00);

    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].data);
      rd_addr = vecs[i].dst;
      #1;
      check($sformatf("vec%0d_dst", i), rd_data, vecs[i].exp_dst);
    end

    // start asserted during SW2 must be dropped, not queued.
    sync();
    op = 2'b10; src = 2'd0; dst = 2'd1; start = 1'b1;
    @(posedge ck); #1;
    start = 1'b0;
    sync();
    check("rej_busy_sw2", busy, 1'b1);
    cnt0 = done_cnt;
    op = 2'b00; dst = 2'd0; data_in = 6'h01; start = 1'b1;
    @(posedge ck); #1;
    start = 1'b0;
    repeat (4) sync();
    check("rej_one_done", done_cnt - cnt0, 1);
    begin
      logic [5:0] t;
      t = m[0]; m[0] = m[1]; m[1] = t;
    end
    for (int i = 0; i < 2; i++) begin
      rd_addr = 2'(i);
      #1;
      check($sformatf("rej_r%0d", i), rd_data, m[i]);
    end

    // Asynchronous reset in the middle of a swap.
    sync();
    op = 2'b10; src = 2'd0; dst = 2'd3; start = 1'b1;
    @(posedge ck); #1;
    start = 1'b0;
    sync();
    #2 rst = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_bus", barramento, 6'h00);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #0.5;
      check($sformatf("arst_r%0d", i), rd_data, 6'h00);
      m[i] = '0;
    end
    cnt0 = done_cnt;
    repeat (2) @(posedge ck);
    #3 rst = 1'b1;
    repeat (6) sync();
    check("arst_no_done", done_cnt - cnt0, 0);
    check("arst_idle", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      check($sformatf("arst_post_r%0d", i), rd_data, 6'h00);
    end

    // 8-bit, 5-register instance.
    run2(2'b00, 3'd0, 3'd4, 8'hA5);
    run2(2'b00, 3'd0, 3'd0, 8'h3C);
    run2(2'b10, 3'd4, 3'd0, 8'h00);
    rd2_check("p_r4", 3'd4, 8'h3C);
    rd2_check("p_r0", 3'd0, 8'hA5);
    run2(2'b00, 3'd0, 3'd1, 8'h77);
    run2(2'b00, 3'd0, 3'd6, 8'hFF);
    rd2_check("p_oob_r0", 3'd0, 8'hA5);
    rd2_check("p_oob_r1", 3'd1, 8'h77);
    rd2_check("p_oob_r2", 3'd2, 8'h00);
    rd2_check("p_oob_r3", 3'd3, 8'h00);
    rd2_check("p_oob_r4", 3'd4, 8'h3C);
    rd2_check("p_rd7", 3'd7, 8'h00);
    rd2_check("p_rd6", 3'd6, 8'h00);
    run2(2'b01, 3'd6, 3'd1, 8'h00);
    rd2_check("p_move_oob", 3'd1, 8'h00);

    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
